fp_quad_sequencer: RTL and testbench
====================================

FP_QUAD_SEQUENCER -- requirements
Module: fp_quad_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, meaning the number of cycles the adder-tree inputs are held stable before the result is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  an operand word is offered.
REQ-005 in_ready  output  1  the block can accept an operand word.
REQ-006 in_data  input  32  IEEE-754 binary32 operand word.
REQ-007 in_sub_op  input  3  subtract-select for the quad; sampled with the first word only.
REQ-008 in_rm  input  3  rounding mode for the quad; sampled with the first word only.
REQ-009 op_a, op_b, op_c, op_d  output  32 each  registered operands driven to the four-operand adder tree.
REQ-010 op_sub  output  3  registered subtract-select to the tree; op_rm  output  3  registered rounding mode to the tree.
REQ-011 add_result  input  32  combinational binary32 result from the tree.
REQ-012 add_flags  input  5  exception flags from the tree.
REQ-013 res_valid  output  1  a result is available.
REQ-014 res_ready  input  1  the consumer accepts the result.
REQ-015 res_data  output  32  captured result.
REQ-016 res_flags  output  5  captured per-quad flags.
REQ-017 sticky_flags  output  5  OR of res_flags over all quads since reset or clear.
REQ-018 flags_clr  input  1  clears sticky_flags.
REQ-019 quad_count  output  16  number of completed result handshakes.

Function
REQ-020 The block SHALL use three states:
- LOAD: accepts four words.
- SETTLE: holds operands and counts SETTLE_CYCLES.
- DONE: presents the result.
REQ-021 in_ready SHALL be 1 exactly when state=LOAD and rst=0; res_valid SHALL be 1 exactly in DONE.
REQ-022 In LOAD, each edge with in_valid&in_ready SHALL store in_data into slot cnt (0→op_a, 1→op_b, 2→op_c, 3→op_d) and then increment the 2-bit cnt.
REQ-023 The cnt=0 accept SHALL also latch in_sub_op→op_sub and in_rm→op_rm; these SHALL NOT change on later words.
REQ-024 The cnt=3 accept SHALL move the block to SETTLE, load the settle timer, and wrap cnt to 0.
REQ-025 Operand outputs SHALL change only on accepts, and SHALL hold through SETTLE and DONE.
REQ-026 Capture timing: if the 4th word is accepted at edge k, res_data<=add_result and res_flags<=add_flags SHALL occur at edge k+SETTLE_CYCLES, and res_valid SHALL rise at that same edge.
REQ-027 In DONE, res_data and res_flags SHALL hold while res_ready=0.
REQ-028 When res_ready=1 in DONE, the block SHALL return to LOAD and increment quad_count, which wraps 0xFFFF→0x0000.
REQ-029 in_ready SHALL stay 0 through SETTLE and DONE; a word offered then SHALL be neither stored nor lost, and remains the upstream's responsibility.
REQ-030 Each capture SHALL set sticky_flags <= sticky_flags | add_flags.
REQ-031 flags_clr alone SHALL set sticky_flags to 0.
REQ-032 If flags_clr and a capture occur on the same edge, sticky_flags SHALL become add_flags.
REQ-033 No combinational path SHALL exist from in_valid or res_ready to any output.

Reset
REQ-034 While rst=1 at an edge, the block SHALL set:
- state to LOAD and cnt to 0;
- op_a..op_d to 0, op_sub to 0, op_rm to 0;
- res_data to 0, res_flags to 0, sticky_flags to 0, quad_count to 0;
- res_valid to 0.
REQ-035 Reset in any state SHALL discard any partial quad, pending settle, or unaccepted result; in_ready SHALL be 1 on the first cycle after rst falls.

Verification
REQ-036 Basic add, SETTLE_CYCLES=2, tree attached: words 0x3F800000, 0x40000000, 0x40400000, 0x40800000 with in_sub_op=000, in_rm=000 -> res_data=0x41200000, res_flags=0, res_valid high exactly 2 cycles after the 4th accept, quad_count=1 after the handshake.
REQ-037 Subtract-select and sampling: in_sub_op=111 on word 0, then changed to 000 for words 1-3 -> op_sub stays 111; with operands 1,2,3,4 the result is (1-2)-(3-4)=0x00000000.
REQ-038 Backpressure: hold res_ready=0 for 10 cycles while in_valid=1 -> in_ready=0, res_data stable, no word stored; res_ready=1 -> the next word goes to op_a.
REQ-039 Flags: operands 0x7F7FFFFF ×4 -> overflow+inexact set in res_flags and sticky_flags; a following normal quad leaves sticky set; flags_clr on that quad's capture edge -> sticky equals that quad's flags (0).
REQ-040 Reset mid-quad: accept 2 words, pulse rst -> outputs as in REQ-034; the next 4 words form a fresh quad with correct result.
REQ-041 Timing sweep: SETTLE_CYCLES=1 and 15 -> res_valid rises 1 and 15 cycles after the 4th accept, respectively.

Source files
------------

// File: rtl/fp_quad_sequencer.sv
// fp_quad_sequencer: gathers four binary32 operand words into registers that
// feed an external four-operand adder tree. It holds them for SETTLE_CYCLES
// cycles, captures the tree's result and flags, and presents them on a
// valid/ready result port.
//
// Ports
//   clk, rst                    clock; synchronous active-high reset
//   in_valid/in_ready/in_data   operand word stream (four words per quad)
//   in_sub_op, in_rm            subtract-select / rounding mode, taken with word 0
//   op_a..op_d, op_sub, op_rm   registered operands and controls to the tree
//   add_result, add_flags       combinational result and flags from the tree
//   res_valid/res_ready         result handshake
//   res_data, res_flags         captured result and flags of the quad
//   sticky_flags, flags_clr     accumulated flags since reset or clear
//   quad_count                  completed result handshakes (wraps)
module fp_quad_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [2:0]  in_sub_op,
    input  logic [2:0]  in_rm,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic [31:0] op_c,
    output logic [31:0] op_d,
    output logic [2:0]  op_sub,
    output logic [2:0]  op_rm,
    input  logic [31:0] add_result,
    input  logic [4:0]  add_flags,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [4:0]  res_flags,
    output logic [4:0]  sticky_flags,
    input  logic        flags_clr,
    output logic [15:0] quad_count
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned FLAG_W  = 5;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TIMER_W = 4;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                        state_q;
    logic [1:0]                    cnt_q;
    logic [TIMER_W-1:0]            timer_q;
    logic [3:0][DATA_W-1:0]        ops_q;
    logic [2:0]                    sub_q;
    logic [2:0]                    rm_q;
    logic [DATA_W-1:0]             res_data_q;
    logic [FLAG_W-1:0]             res_flags_q;
    logic [FLAG_W-1:0]             sticky_q;
    logic [CNT_W-1:0]              quad_count_q;
    logic                          capture;

    // The timer is loaded with SETTLE_CYCLES-1 on the 4th accept and the
    // capture happens on the edge where it is already zero. This puts the
    // capture exactly SETTLE_CYCLES edges after the 4th accept.
    assign capture = (state_q == SETTLE) && (timer_q == '0);

    // Ready depends only on state and reset, never on in_valid or res_ready.
    assign in_ready  = (state_q == LOAD) && !rst;
    assign res_valid = (state_q == DONE);

    assign op_a         = ops_q[0];
    assign op_b         = ops_q[1];
    assign op_c         = ops_q[2];
    assign op_d         = ops_q[3];
    assign op_sub       = sub_q;
    assign op_rm        = rm_q;
    assign res_data     = res_data_q;
    assign res_flags    = res_flags_q;
    assign sticky_flags = sticky_q;
    assign quad_count   = quad_count_q;

    // Sequencer state, operand slots, result capture and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LOAD;
            cnt_q        <= '0;
            timer_q      <= '0;
            ops_q        <= '0;
            sub_q        <= '0;
            rm_q         <= '0;
            res_data_q   <= '0;
            res_flags_q  <= '0;
            sticky_q     <= '0;
            quad_count_q <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_valid) begin
                        ops_q[cnt_q] <= in_data;
                        if (cnt_q == 2'd0) begin
                            sub_q <= in_sub_op;
                            rm_q  <= in_rm;
                        end
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_q <= SETTLE;
                            timer_q <= TIMER_W'(SETTLE_CYCLES - 1);
                        end
                    end
                end
                SETTLE: begin
                    if (capture) begin
                        res_data_q  <= add_result;
                        res_flags_q <= add_flags;
                        state_q     <= DONE;
                    end else begin
                        timer_q <= timer_q - TIMER_W'(1);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_q      <= LOAD;
                        quad_count_q <= quad_count_q + CNT_W'(1);
                    end
                end
                default: state_q <= LOAD;
            endcase

            // A clear on a capture edge drops the history and keeps only this quad's flags.
            if (capture) begin
                sticky_q <= (flags_clr ? '0 : sticky_q) | add_flags;
            end else if (flags_clr) begin
                sticky_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fp_quad_sequencer.sv
// Directed bench for fp_quad_sequencer: main instance with SETTLE_CYCLES=2,
// plus instances with 1 and 15 for the settle-timing sweep. A table-driven
// adder-tree model supplies hand-computed results for the operand sets used.
module tb_fp_quad_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] in_data;
    logic [2:0]  in_sub_op;
    logic [2:0]  in_rm;
    logic        flags_clr;

    // Main instance (SETTLE_CYCLES=2)
    logic        v2, rdy2, rv2, rr2;
    logic [31:0] a2, b2, c2, d2, ar2, rd2;
    logic [2:0]  sub2, rm2;
    logic [4:0]  af2, rf2, sf2;
    logic [15:0] qc2;

    // Sweep instances (SETTLE_CYCLES=1 and 15)
    logic        vs, rdy1, rv1, rdy15, rv15, rrs;
    logic [31:0] a1, b1, c1, d1, ar1, rd1;
    logic [31:0] a15, b15, c15, d15, ar15, rd15;
    logic [2:0]  sub1, rm1, sub15, rm15;
    logic [4:0]  af1, rf1, sf1, af15, rf15, sf15;
    logic [15:0] qc1, qc15;

    int errors = 0;
    int checks = 0;

    // Flag order {NV, DZ, OF, UF, NX}.
    function automatic logic [36:0] tree(input logic [31:0] a, b, c, d, input logic [2:0] s);
        if (a == 32'h3F800000 && b == 32'h40000000 && c == 32'h40400000 && d == 32'h40800000) begin
            if (s == 3'b000) return {32'h41200000, 5'b00000};   // 1+2+3+4 = 10
            if (s == 3'b111) return {32'h00000000, 5'b00000};   // (1-2)-(3-4) = 0
        end
        if (a == 32'h7F7FFFFF && b == 32'h7F7FFFFF && c == 32'h7F7FFFFF && d == 32'h7F7FFFFF
            && s == 3'b000)
            return {32'h7F800000, 5'b00101};                    // overflow + inexact
        return {32'h7FC00000, 5'b10000};
    endfunction

    assign {ar2, af2}   = tree(a2, b2, c2, d2, sub2);
    assign {ar1, af1}   = tree(a1, b1, c1, d1, sub1);
    assign {ar15, af15} = tree(a15, b15, c15, d15, sub15);

    fp_quad_sequencer #(.SETTLE_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2), .in_data(in_data),
        .in_sub_op(in_sub_op), .in_rm(in_rm), .op_a(a2), .op_b(b2), .op_c(c2), .op_d(d2),
        .op_sub(sub2), .op_rm(rm2), .add_result(ar2), .add_flags(af2), .res_valid(rv2),
        .res_ready(rr2), .res_data(rd2), .res_flags(rf2), .sticky_flags(sf2),
        .flags_clr(flags_clr), .quad_count(qc2));

    fp_quad_sequencer #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(vs), .in_ready(rdy1), .in_data(in_data),
        .in_sub_op(in_sub_op), .in_rm(in_rm), .op_a(a1), .op_b(b1), .op_c(c1), .op_d(d1),
        .op_sub(sub1), .op_rm(rm1), .add_result(ar1), .add_flags(af1), .res_valid(rv1),
        .res_ready(rrs), .res_data(rd1), .res_flags(rf1), .sticky_flags(sf1),
        .flags_clr(flags_clr), .quad_count(qc1));

    fp_quad_sequencer #(.SETTLE_CYCLES(15)) dut15 (
        .clk(clk), .rst(rst), .in_valid(vs), .in_ready(rdy15), .in_data(in_data),
        .in_sub_op(in_sub_op), .in_rm(in_rm), .op_a(a15), .op_b(b15), .op_c(c15), .op_d(d15),
        .op_sub(sub15), .op_rm(rm15), .add_result(ar15), .add_flags(af15), .res_valid(rv15),
        .res_ready(rrs), .res_data(rd15), .res_flags(rf15), .sticky_flags(sf15),
        .flags_clr(flags_clr), .quad_count(qc15));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Four back-to-back accepts into the main instance; returns just after the 4th accept edge.
    task automatic load_quad(input logic [31:0] w0, w1, w2, w3,
                             input logic [2:0] s0, s_rest, r0, r_rest, input string tag);
        v2 = 1'b1;
        in_sub_op = s0;     in_rm = r0;     in_data = w0;
        chk({tag, " ready w0"}, 32'(rdy2), 32'd1);
        tick();
        in_sub_op = s_rest; in_rm = r_rest; in_data = w1;
        chk({tag, " ready w1"}, 32'(rdy2), 32'd1);
        tick();
        in_data = w2;
        chk({tag, " ready w2"}, 32'(rdy2), 32'd1);
        tick();
        in_data = w3;
        chk({tag, " ready w3"}, 32'(rdy2), 32'd1);
        tick();
        v2 = 1'b0;
    endtask

    task automatic handshake2(input logic [15:0] exp_qc, input string tag);
        rr2 = 1'b1;
        tick();
        rr2 = 1'b0;
        chk({tag, " qcount"}, 32'(qc2), 32'(exp_qc));
        chk({tag, " back to load"}, 32'(rdy2), 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_sub_op = '0; in_rm = '0; flags_clr = 1'b0;
        v2 = 1'b0; rr2 = 1'b0; vs = 1'b0; rrs = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst op_a", a2, 32'h0);
        chk("rst res_valid", 32'(rv2), 32'd0);
        chk("rst in_ready while rst", 32'(rdy2), 32'd0);
        chk("rst qcount", 32'(qc2), 32'd0);
        chk("rst sticky", 32'(sf2), 32'd0);
        rst = 1'b0;
        #1;
        chk("in_ready after rst", 32'(rdy2), 32'd1);

        // Basic add: result exactly 2 cycles after the 4th accept
        load_quad(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                  3'b000, 3'b000, 3'b000, 3'b000, "add");
        chk("add op_d", d2, 32'h40800000);
        chk("add valid k", 32'(rv2), 32'd0);
        chk("add in_ready settle", 32'(rdy2), 32'd0);
        tick();
        chk("add valid k+1", 32'(rv2), 32'd0);
        tick();
        chk("add valid k+2", 32'(rv2), 32'd1);
        chk("add res_data", rd2, 32'h41200000);
        chk("add res_flags", 32'(rf2), 32'd0);
        handshake2(16'd1, "add");

        // Subtract-select / rounding mode latched from word 0 only
        load_quad(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                  3'b111, 3'b000, 3'b101, 3'b000, "sub");
        chk("sub op_sub", 32'(sub2), 32'd7);
        chk("sub op_rm", 32'(rm2), 32'd5);
        tick(); tick();
        chk("sub valid", 32'(rv2), 32'd1);
        chk("sub res_data", rd2, 32'h00000000);

        // Backpressure: word offered during DONE is neither stored nor lost
        v2 = 1'b1; in_data = 32'hAAAA5555;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp in_ready", 32'(rdy2), 32'd0);
            chk("bp res_valid", 32'(rv2), 32'd1);
            chk("bp res_data", rd2, 32'h00000000);
            chk("bp op_a held", a2, 32'h3F800000);
        end
        handshake2(16'd2, "bp");
        tick();
        chk("bp next word op_a", a2, 32'hAAAA5555);
        in_data = 32'h12345678;
        tick();
        v2 = 1'b0;
        chk("partial op_b", b2, 32'h12345678);

        // Reset mid-quad discards the partial quad
        rst = 1'b1;
        tick();
        chk("midrst op_a", a2, 32'h0);
        chk("midrst op_b", b2, 32'h0);
        chk("midrst op_sub", 32'(sub2), 32'd0);
        chk("midrst res_data", rd2, 32'h0);
        chk("midrst qcount", 32'(qc2), 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst in_ready", 32'(rdy2), 32'd1);
        load_quad(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                  3'b000, 3'b000, 3'b000, 3'b000, "fresh");
        chk("fresh op_a", a2, 32'h3F800000);
        chk("fresh op_b", b2, 32'h40000000);
        tick(); tick();
        chk("fresh res_data", rd2, 32'h41200000);
        handshake2(16'd1, "fresh");

        // Flags: overflow quad sets res_flags and sticky
        load_quad(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF,
                  3'b000, 3'b000, 3'b000, 3'b000, "ovf");
        tick(); tick();
        chk("ovf res_data", rd2, 32'h7F800000);
        chk("ovf res_flags", 32'(rf2), 32'h05);
        chk("ovf sticky", 32'(sf2), 32'h05);
        handshake2(16'd2, "ovf");

        // A clean quad leaves sticky set
        load_quad(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                  3'b000, 3'b000, 3'b000, 3'b000, "clean");
        tick(); tick();
        chk("clean res_flags", 32'(rf2), 32'h00);
        chk("clean sticky kept", 32'(sf2), 32'h05);
        handshake2(16'd3, "clean");

        // flags_clr on the capture edge: sticky becomes this quad's flags
        load_quad(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                  3'b000, 3'b000, 3'b000, 3'b000, "clrcap");
        tick();
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        chk("clrcap valid", 32'(rv2), 32'd1);
        chk("clrcap sticky", 32'(sf2), 32'h00);
        handshake2(16'd4, "clrcap");

        // flags_clr on its own wipes sticky
        load_quad(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF,
                  3'b000, 3'b000, 3'b000, 3'b000, "clralone");
        tick(); tick();
        chk("clralone sticky set", 32'(sf2), 32'h05);
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        chk("clralone sticky", 32'(sf2), 32'h00);
        chk("clralone res_flags held", 32'(rf2), 32'h05);
        handshake2(16'd5, "clralone");

        // Settle-time sweep: SETTLE_CYCLES=1 and 15 share one quad
        vs = 1'b1; in_sub_op = 3'b000; in_rm = 3'b000;
        in_data = 32'h3F800000; tick();
        in_data = 32'h40000000; tick();
        in_data = 32'h40400000; tick();
        in_data = 32'h40800000; tick();
        vs = 1'b0;
        chk("s1 valid k", 32'(rv1), 32'd0);
        chk("s15 valid k", 32'(rv15), 32'd0);
        tick();
        chk("s1 valid k+1", 32'(rv1), 32'd1);
        chk("s1 res_data", rd1, 32'h41200000);
        for (int i = 2; i < 15; i++) tick();
        chk("s15 valid k+14", 32'(rv15), 32'd0);
        tick();
        chk("s15 valid k+15", 32'(rv15), 32'd1);
        chk("s15 res_data", rd15, 32'h41200000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
